// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator sequencing controller.
//   - cic_state_t : controller phases (FLUSH -> SETTLE -> RUN)
//   - RATIO_W     : width of the CIC decimation_ratio input
//   - SAMPLE_W    : width of the CIC d_out sample
//   - CIC_DEFAULT_RATIO / CIC_MIN_RATIO : ratio loaded at reset / smallest
//     ratio the controller will ever hand to the CIC
package cic_pkg;

    localparam int RATIO_W  = 16;
    localparam int SAMPLE_W = 8;

    localparam logic [RATIO_W-1:0] CIC_DEFAULT_RATIO = 16'd8192;
    localparam logic [RATIO_W-1:0] CIC_MIN_RATIO     = 16'd4;

    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } cic_state_t;

endpackage

// File: rtl/cic_strobe_det.sv
// Rising-edge detector for the CIC's decimated clock.
// Ports:
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   d_clk  : CIC d_clk output (generated in the clk domain)
//   strobe : high for the single clk cycle in which d_clk is seen rising
// d_out changes on the same CIC edge as d_clk, so it is stable in the
// strobe cycle and can be captured directly by the consumer.
module cic_strobe_det (
    input  logic clk,
    input  logic rst,
    input  logic d_clk,
    output logic strobe
);

    logic d_clk_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_clk_q <= 1'b0;
        end else begin
            d_clk_q <= d_clk;
        end
    end

    assign strobe = d_clk & ~d_clk_q;

endmodule

// File: rtl/cic_ctrl.sv
// Sequencing controller for the 5-stage CIC decimator.
// Owns the CIC reset and ratio; on every (re)configuration it holds the CIC
// in reset to flush the integrators, discards the settling samples, and then
// forwards clean samples downstream.
// Ports:
//   clk, rst                 : system clock, asynchronous active-low reset
//   cfg_ratio/valid/ready    : host ratio request handshake
//   cfg_err                  : one-cycle pulse, request below MIN_RATIO
//   cic_rst, cic_ratio       : drive the CIC reset / decimation_ratio
//   cic_d_clk, cic_d_out     : CIC decimated clock and sample
//   out_data, out_valid      : forwarded sample, one-cycle strobe
//   locked                   : high while forwarding (RUN)
//   drop_cnt                 : samples discarded since last (re)configuration
module cic_ctrl
    import cic_pkg::*;
#(
    parameter logic [RATIO_W-1:0] DEFAULT_RATIO  = CIC_DEFAULT_RATIO,
    parameter logic [RATIO_W-1:0] MIN_RATIO      = CIC_MIN_RATIO,
    parameter int                 FLUSH_CYCLES   = 8,
    parameter int                 SETTLE_SAMPLES = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic        [RATIO_W-1:0]  cfg_ratio,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    output logic                       cfg_err,
    output logic                       cic_rst,
    output logic        [RATIO_W-1:0]  cic_ratio,
    input  logic                       cic_d_clk,
    input  logic signed [SAMPLE_W-1:0] cic_d_out,
    output logic signed [SAMPLE_W-1:0] out_data,
    output logic                       out_valid,
    output logic                       locked,
    output logic        [7:0]          drop_cnt
);

    localparam int FLUSH_W  = $clog2(FLUSH_CYCLES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_SAMPLES + 1);
    localparam logic [FLUSH_W-1:0]  FLUSH_LAST  = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_SAMPLES - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    cic_state_t          state;
    cic_state_t          state_nxt;
    logic [FLUSH_W-1:0]  flush_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                strobe;
    logic                cfg_take;
    logic                ratio_ok;
    logic                req_ok;
    logic                req_bad;

    cic_strobe_det u_strobe_det (
        .clk    (clk),
        .rst    (rst),
        .d_clk  (cic_d_clk),
        .strobe (strobe)
    );

    // cic_rst decodes the state flop, so an async reset reaches the CIC
    // without waiting for a clock edge.
    assign cic_rst   = (state == FLUSH);
    assign locked    = (state == RUN);
    assign cfg_ready = (state == RUN);

    assign cfg_take = cfg_valid & cfg_ready;
    assign ratio_ok = (cfg_ratio >= MIN_RATIO);
    assign req_ok   = cfg_take & ratio_ok;
    assign req_bad  = cfg_take & ~ratio_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FLUSH:   if (flush_cnt == FLUSH_LAST) state_nxt = SETTLE;
            SETTLE:  if (strobe && (settle_cnt == SETTLE_LAST)) state_nxt = RUN;
            RUN:     if (req_ok) state_nxt = FLUSH;
            default: state_nxt = FLUSH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt  <= '0;
            settle_cnt <= '0;
            drop_cnt   <= '0;
            cic_ratio  <= DEFAULT_RATIO;
            cfg_err    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            cfg_err   <= req_bad;
            out_valid <= 1'b0;
            case (state)
                FLUSH: begin
                    // Strobes are ignored here: the CIC is held in reset.
                    if (flush_cnt == FLUSH_LAST) begin
                        flush_cnt  <= '0;
                        settle_cnt <= '0;
                        drop_cnt   <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    // The sample that completes settling is dropped as well.
                    if (strobe) begin
                        drop_cnt   <= sat_inc8(drop_cnt);
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // A sample arriving with an accepted request is still
                    // forwarded; the flush starts on the following cycle.
                    if (strobe) begin
                        out_data  <= cic_d_out;
                        out_valid <= 1'b1;
                    end
                    if (req_ok) begin
                        cic_ratio  <= cfg_ratio;
                        flush_cnt  <= '0;
                        settle_cnt <= '0;
                        drop_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_ctrl.sv
module tb_cic_ctrl;

    localparam int SETTLE = 6;

    typedef struct {
        logic signed [7:0] val;
        int                t;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [15:0]        cfg_ratio = 16'd0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic               cfg_err;
    logic               cic_rst;
    logic [15:0]        cic_ratio;
    logic               cic_d_clk;
    logic signed [7:0]  cic_d_out;
    logic signed [7:0]  out_data;
    logic               out_valid;
    logic               locked;
    logic [7:0]         drop_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    exp_t exp_q[$];

    // CIC model state
    int                m_cnt = 0;
    int                m_k = 0;
    int                m_seq = 0;
    logic              m_dclk = 1'b0;
    logic              m_edge = 1'b0;
    logic              m_pend = 1'b0;
    logic signed [7:0] m_dout = 8'sd0;
    logic signed [7:0] m_pval = 8'sd0;

    assign cic_d_clk = m_dclk;
    assign cic_d_out = m_dout;

    always #5 clk = ~clk;

    cic_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_ratio (cfg_ratio),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cic_rst   (cic_rst),
        .cic_ratio (cic_ratio),
        .cic_d_clk (cic_d_clk),
        .cic_d_out (cic_d_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .locked    (locked),
        .drop_cnt  (drop_cnt)
    );

    // CIC behavioural model: period = ratio clocks, first rising d_clk
    // ratio/2 clocks after cic_rst releases. Samples 7+ after a release are
    // expected downstream, provided the CIC is not reset in the strobe cycle.
    task automatic model_run();
        int   nxt;
        int   half;
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (cic_rst) begin
                m_cnt  <= 0;
                m_k    <= 0;
                m_dclk <= 1'b0;
                m_edge <= 1'b0;
                m_pend <= 1'b0;
            end else begin
                if (m_pend) begin
                    e.val = m_pval;
                    e.t   = cyc;
                    exp_q.push_back(e);
                end
                half = int'(cic_ratio) / 2;
                nxt  = (m_cnt == int'(cic_ratio) - 1) ? 0 : m_cnt + 1;
                m_cnt  <= nxt;
                m_dclk <= (nxt >= half);
                m_edge <= (nxt == half);
                m_pend <= 1'b0;
                if (nxt == half) begin
                    m_dout <= 8'(m_seq * 53 + 17);
                    m_pval <= 8'(m_seq * 53 + 17);
                    m_pend <= (m_k + 1 > SETTLE);
                    m_k    <= m_k + 1;
                    m_seq  <= m_seq + 1;
                end
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected: out_valid with out_data=%0d, no sample expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.val) begin
                        miscompares++;
                        $display("FAIL sb_data: out_data=%0d, expected %0d", out_data, e.val);
                    end
                end
            end else if (exp_q.size() > 0 && (cyc - exp_q[0].t) > 3) begin
                vectors++;
                miscompares++;
                e = exp_q.pop_front();
                $display("FAIL sb_missing: no out_valid for sample %0d, expected one", e.val);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cic_rst, locked, cfg_ready, cfg_err, out_valid} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_ctrl: {cic_rst,locked,ready,err,valid}=%b, expected 10000",
                     {cic_rst, locked, cfg_ready, cfg_err, out_valid});
        end
        vectors++;
        if (cic_ratio !== 16'd8192) begin
            miscompares++;
            $display("FAIL reset_ratio: cic_ratio=%0d, expected 8192", cic_ratio);
        end
        vectors++;
        if (drop_cnt !== 8'd0 || out_data !== 8'sd0) begin
            miscompares++;
            $display("FAIL reset_data: drop_cnt=%0d out_data=%0d, expected 0 0", drop_cnt, out_data);
        end
    endtask

    task automatic test_lock_default();
        int n;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (cic_rst === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 8) begin
            miscompares++;
            $display("FAIL init_flush_len: cic_rst high %0d clocks, expected 8", n);
        end
        n = 0;
        while (locked !== 1'b1 && n < 70000) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (locked !== 1'b1 || drop_cnt !== 8'd6) begin
            miscompares++;
            $display("FAIL init_lock: locked=%b drop_cnt=%0d, expected 1 6", locked, drop_cnt);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 9000) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== m_dout) begin
            miscompares++;
            $display("FAIL init_first_sample: valid=%b data=%0d, expected 1 %0d", out_valid, out_data, m_dout);
        end
    endtask

    task automatic test_reconfig();
        int n;
        @(negedge clk);
        cfg_ratio = 16'd16;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        vectors++;
        if (cic_ratio !== 16'd16 || locked !== 1'b0 || cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg16_take: ratio=%0d locked=%b ready=%b, expected 16 0 0", cic_ratio, locked, cfg_ready);
        end
        n = 0;
        while (cic_rst === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 8) begin
            miscompares++;
            $display("FAIL cfg16_flush_len: cic_rst high %0d clocks, expected 8", n);
        end
        n = 0;
        while (locked !== 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (locked !== 1'b1 || drop_cnt !== 8'd6) begin
            miscompares++;
            $display("FAIL cfg16_lock: locked=%b drop_cnt=%0d, expected 1 6", locked, drop_cnt);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL cfg16_period: strobe spacing %0d clocks, expected 16", n);
        end
    endtask

    task automatic test_bad_ratio();
        int n;
        @(negedge clk);
        cfg_ratio = 16'd3;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        vectors++;
        if (cfg_err !== 1'b1 || cic_ratio !== 16'd16 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_ratio_err: err=%b ratio=%0d locked=%b, expected 1 16 1", cfg_err, cic_ratio, locked);
        end
        @(negedge clk);
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_ratio_pulse: cfg_err=%b one clock later, expected 0", cfg_err);
        end
        n = 0;
        repeat (48) begin
            @(negedge clk);
            if (out_valid === 1'b1) n++;
        end
        vectors++;
        if (n != 3 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_ratio_stream: %0d samples in 48 clocks locked=%b, expected 3 1", n, locked);
        end
    endtask

    task automatic test_req_on_strobe();
        int n;
        n = 0;
        @(negedge clk);
        while (m_edge !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        cfg_ratio = 16'd16;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || cic_rst !== 1'b1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_fwd: valid=%b cic_rst=%b locked=%b, expected 1 1 0", out_valid, cic_rst, locked);
        end
        n = 0;
        repeat (8 + 6 * 16) begin
            @(negedge clk);
            if (out_valid === 1'b1) n++;
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL same_cycle_quiet: %0d out_valid during resync, expected 0", n);
        end
        n = 0;
        while (locked !== 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_hold_in_settle();
        int n;
        int bad;
        @(negedge clk);
        cfg_ratio = 16'd64;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        vectors++;
        if (cic_ratio !== 16'd64) begin
            miscompares++;
            $display("FAIL hold_ratio64: cic_ratio=%0d, expected 64", cic_ratio);
        end
        n = 0;
        while (cic_rst !== 1'b0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        cfg_valid = 1'b1;
        bad = 0;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 2000) begin
            if (cic_rst !== 1'b0 || locked !== 1'b0) bad++;
            n++;
            @(negedge clk);
        end
        vectors++;
        if (bad != 0 || cfg_ready !== 1'b1 || locked !== 1'b1 || drop_cnt !== 8'd6) begin
            miscompares++;
            $display("FAIL hold_not_taken: early=%0d ready=%b locked=%b drops=%0d, expected 0 1 1 6",
                     bad, cfg_ready, locked, drop_cnt);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        vectors++;
        if (cic_rst !== 1'b1 || locked !== 1'b0 || cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_taken_in_run: cic_rst=%b locked=%b ready=%b, expected 1 0 0", cic_rst, locked, cfg_ready);
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (drop_cnt !== 8'd3 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({cic_rst, locked, cfg_ready, cfg_err, out_valid} !== 5'b10000 ||
            cic_ratio !== 16'd8192 || drop_cnt !== 8'd0 || out_data !== 8'sd0) begin
            miscompares++;
            $display("FAIL async_reset: ctrl=%b ratio=%0d drops=%0d data=%0d, expected 10000 8192 0 0",
                     {cic_rst, locked, cfg_ready, cfg_err, out_valid}, cic_ratio, drop_cnt, out_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (cic_rst === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 8 || cic_ratio !== 16'd8192) begin
            miscompares++;
            $display("FAIL restart_flush: cic_rst high %0d ratio=%0d, expected 8 8192", n, cic_ratio);
        end
        n = 0;
        while (drop_cnt !== 8'd1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (drop_cnt !== 8'd1 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_settle: drop_cnt=%0d locked=%b, expected 1 0", drop_cnt, locked);
        end
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d samples never forwarded, expected 0", exp_q.size());
        end
    endtask

    initial begin
        fork
            model_run();
            monitor();
        join_none
        test_reset();
        test_lock_default();
        test_reconfig();
        test_bad_ratio();
        test_req_on_strobe();
        test_hold_in_settle();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cic_ctrl.md
Name: cic_ctrl

Overview:
- Sequencing controller for the 5-stage CIC decimator.
- Owns the CIC's reset and decimation_ratio inputs.
- Applies ratio changes safely: holds the CIC in reset to flush its integrators, then discards the settling output samples.
- Forwards clean decimated samples downstream as single-cycle valid strobes and reports status to the host/config side.

Parameters:
- DEFAULT_RATIO, 16'd8192: ratio loaded at reset.
- MIN_RATIO, 16'd4: smallest accepted ratio; requests below it are rejected.
- FLUSH_CYCLES, 8: clocks cic_rst is held high per (re)configuration.
- SETTLE_SAMPLES, 6: output samples discarded after flush (5 comb stages + 1 pipeline register).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- cfg_ratio, in, 16: requested decimation ratio.
- cfg_valid, in, 1: request strobe, sampled when cfg_ready=1.
- cfg_ready, out, 1: controller can accept a request.
- cfg_err, out, 1: one-cycle pulse, request rejected (ratio < MIN_RATIO).
- cic_rst, out, 1: synchronous active-high reset to the CIC.
- cic_ratio, out, 16: decimation_ratio to the CIC.
- cic_d_clk, in, 1: CIC d_clk output.
- cic_d_out, in, 8 signed: CIC d_out.
- out_data, out, 8 signed: forwarded sample.
- out_valid, out, 1: one-cycle strobe, out_data is valid.
- locked, out, 1: high in RUN.
- drop_cnt, out, 8: samples discarded since the last (re)configuration, saturating at 255.

Behaviour:
- Reset (rst=0, async) values:
  - state=FLUSH, cic_rst=1, cic_ratio=DEFAULT_RATIO, flush counter=0, drop_cnt=0.
  - out_data=0, out_valid=0, locked=0, cfg_ready=0, cfg_err=0, d_clk delay reg=0.
- Edge detect:
  - d_clk_q <= cic_d_clk every clock.
  - strobe = cic_d_clk & ~d_clk_q.
  - cic_d_out is stable on the strobe cycle (both change on the same CIC edge).
- FLUSH:
  - cic_rst=1; counter increments each clock.
  - When counter==FLUSH_CYCLES-1: clear counter, drop_cnt=0, cic_rst=0 next cycle, go to SETTLE.
  - Strobes are ignored.
- SETTLE:
  - cic_rst=0. Each strobe increments drop_cnt (saturating) and the settle counter.
  - The strobe that makes the settle count equal SETTLE_SAMPLES goes to RUN; that sample is also discarded.
  - out_valid stays 0.
- RUN:
  - locked=1.
  - On each strobe: out_data <= cic_d_out, out_valid=1 for exactly one clock (latency 1 clock after strobe detect).
  - out_data holds its value between strobes.
- cfg_ready=1 only in RUN. A request is taken when cfg_valid & cfg_ready.
  - Valid request (cfg_ratio >= MIN_RATIO): cic_ratio <= cfg_ratio, locked=0, state=FLUSH, counters cleared, cfg_ready drops next cycle.
  - Invalid request: cfg_err pulses 1 clock; cic_ratio and state unchanged; stays in RUN.
- Request and strobe in the same RUN cycle: the sample is still forwarded (out_valid=1), then FLUSH.
- cfg_valid while not ready: ignored; the requester must hold it.
- Request equal to the current ratio: still re-flushes. This is the explicit "resync" mechanism.
- Strobe on the last FLUSH cycle: ignored.
- Async reset mid-operation: all state returns to the reset values immediately; cic_rst asserts combinationally from the reset flop output (next clk edge at the latest).
- Ratio width rule: cic_ratio is always >= MIN_RATIO, so the CIC's half-period compare never equals ratio-1.

Decomposition:
- Shared package (cic_pkg):
  - state enum {FLUSH, SETTLE, RUN}.
  - RATIO_W=16, SAMPLE_W=8.
  - Defaults for DEFAULT_RATIO and MIN_RATIO.
- One natural sub-module: cic_strobe_det (d_clk synchroniser/rising-edge detector, 1-bit in, strobe out).
- The FSM and counters stay in cic_ctrl.

Test Plan:
1. Reset release with CIC model at ratio 8192, no cfg:
   - cic_rst high for 8 clocks after rst rises.
   - First 6 strobes dropped (drop_cnt=6), locked=1.
   - 7th strobe gives out_valid with out_data = model d_out.
2. In RUN, cfg_ratio=16, cfg_valid=1 for 1 clock:
   - cic_ratio=16, cic_rst high 8 clocks, locked=0.
   - 6 drops, then strobes every 16 clocks forwarded.
3. In RUN, cfg_ratio=3:
   - cfg_err pulses 1 clock; cic_ratio stays 16; locked stays 1; output stream uninterrupted.
4. Request asserted on the same cycle as a strobe:
   - out_valid=1 with that sample, then FLUSH; no further out_valid for 8 + 6×ratio clocks.
5. cfg_valid held during SETTLE with ratio 64:
   - Not taken until RUN (cfg_ready=0). Taken on the first RUN cycle, then re-flush.
6. rst pulled low during SETTLE (drop_cnt=3):
   - Outputs return to reset values asynchronously, cic_ratio=8192, full sequence restarts.
